bcd_stream_decoder: RTL and testbench
=====================================

Name: bcd_stream_decoder

Overview:
- Streaming BCD-to-decimal decoder: the inverse of the team's 10-line-to-BCD encoder.
- Accepts 4-bit BCD digits on a valid/ready input and emits a 10-bit one-hot decimal line vector on a valid/ready output.
- A 2-entry output buffer absorbs backpressure.
- Flags invalid codes (10-15) and keeps a digit counter and a sticky error flag.
- Sits between a BCD digit source (e.g. the encoder stage) and display or decimal-line logic.

Parameters:
CNT_W, 8, width of digit_cnt (and err_cnt when enabled); wraps modulo 2^CNT_W.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  in_bcd holds a digit
in_ready  output  1  block can accept a digit this cycle
in_bcd  input  4  BCD digit, 0-9 valid, 10-15 invalid
out_valid  output  1  head buffer entry valid
out_ready  input  1  consumer accepts head entry this cycle
out_y  output  10  one-hot decimal lines of head entry (bit k = digit k)
out_err  output  1  head entry came from an invalid code
digit_cnt  output  CNT_W  count of accepted valid (0-9) digits
err_sticky  output  1  set by any accepted invalid code
clr_err  input  1  synchronous clear of err_sticky

Behaviour:
- Reset (rst=1 at an edge):
  - Occupancy FSM goes to EMPTY; both buffer entries are invalidated.
  - digit_cnt=0, err_sticky=0.
  - While rst=1, in_ready=0.
  - Reset mid-operation discards buffered entries without emitting them.
- Handshakes:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_valid/in_bcd may change freely when in_ready=0.
- Decode, performed at push:
  - Code c in 0..9: entry y = 10'b1 << c, err = 0.
  - Code 10..15: entry y = 10'b0, err = 1.
  - The entry is written into the buffer tail.
- Occupancy FSM:
  - States: EMPTY (0 entries), ONE (1), FULL (2).
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> FULL; !push & pop -> EMPTY; push & pop -> ONE (new entry becomes head next cycle).
  - FULL: pop -> ONE; no push possible.
- in_ready = !rst & (state != FULL). It depends only on registered state; there is no combinational path from out_ready.
- Outputs:
  - out_valid = (state != EMPTY).
  - When out_valid=0: out_y=0, out_err=0.
  - out_y/out_err are driven from the head entry only. They stay stable while out_valid & !out_ready.
- Latency: a digit pushed at edge N into an EMPTY buffer is presented on out_y in the cycle after edge N (1 cycle). Throughput is 1 digit/cycle with out_ready held high.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- digit_cnt:
  - +1 on each push of a valid code, counted at push, not at pop.
  - Wraps 2^CNT_W-1 -> 0.
  - Not incremented for invalid codes.
- err_sticky:
  - Set on push of an invalid code.
  - Cleared by clr_err.
  - If both occur in the same cycle, set wins.

Optional Feature:
BCD_DEC_ERR_CNT_EN:
- Defined:
  - Adds output port err_cnt [CNT_W-1:0].
  - Reset to 0; +1 on each push of an invalid code; saturates at 2^CNT_W-1 (no wrap).
  - clr_err also clears err_cnt. If clr_err and an invalid push occur in the same cycle, err_cnt = 1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then out_ready=1 and push digits 0..9 back-to-back.
  -> out_y = 1,2,4,...,512 in order, each exactly 1 cycle after its push.
  -> out_err=0 throughout; digit_cnt=10; err_sticky=0.
- Backpressure: out_ready=0, push 3 then 7.
  -> in_ready=0 after the second push; out_y holds 10'd8.
  -> Raise out_ready: out_y=8, then 128, then out_valid=0 and out_y=0.
- Invalid code: push 12.
  -> Entry has out_y=0, out_err=1; err_sticky=1; digit_cnt unchanged.
  -> Assert clr_err alone: err_sticky=0.
  -> Assert clr_err in the same cycle as a push of 15: err_sticky stays 1.
- Simultaneous push/pop in ONE state for 20 cycles with alternating digits 5/9.
  -> State stays ONE; outputs alternate 32/512 with no drops.
- Reset mid-operation: fill buffer FULL, assert rst for 1 cycle.
  -> Next cycle out_valid=0, in_ready=1, digit_cnt=0, err_sticky=0; buffered digits are never emitted.
- Wrap/saturation: CNT_W=4; push 17 valid digits.
  -> digit_cnt=1.
  -> With BCD_DEC_ERR_CNT_EN defined, push 20 invalid codes: err_cnt=15 (saturated).

Source files
------------

// File: rtl/bcd_stream_decoder.sv
// Streaming BCD-to-decimal decoder with a 2-entry output buffer, digit counter and sticky error.
// Optional macro BCD_DEC_ERR_CNT_EN adds a saturating invalid-code counter port err_cnt.
module bcd_stream_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_bcd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_y,
  output logic             out_err,
  output logic [CNT_W-1:0] digit_cnt,
  output logic             err_sticky,
  input  logic             clr_err
`ifdef BCD_DEC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t             state_q, state_d;
  logic [9:0]         head_y_q, head_y_d, tail_y_q, tail_y_d;
  logic               head_err_q, head_err_d, tail_err_q, tail_err_d;
  logic [CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
  logic               err_sticky_q, err_sticky_d;

  logic               push, pop;
  logic               new_ok;
  logic [9:0]         new_y;

  assign in_ready  = !rst && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign new_ok = (in_bcd <= 4'd9);
  assign new_y  = new_ok ? (10'b1 << in_bcd) : 10'b0;

  assign out_y      = out_valid ? head_y_q : 10'b0;
  assign out_err    = out_valid ? head_err_q : 1'b0;
  assign digit_cnt  = digit_cnt_q;
  assign err_sticky = err_sticky_q;

  always_comb begin
    state_d      = state_q;
    head_y_d     = head_y_q;
    head_err_d   = head_err_q;
    tail_y_d     = tail_y_q;
    tail_err_d   = tail_err_q;
    digit_cnt_d  = digit_cnt_q;
    err_sticky_d = err_sticky_q;

    case (state_q)
      EMPTY: begin
        if (push) begin
          head_y_d   = new_y;
          head_err_d = !new_ok;
          state_d    = ONE;
        end
      end
      ONE: begin
        // With push and pop together the new entry replaces the departing head.
        if (push && pop) begin
          head_y_d   = new_y;
          head_err_d = !new_ok;
        end else if (push) begin
          tail_y_d   = new_y;
          tail_err_d = !new_ok;
          state_d    = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_y_d   = tail_y_q;
          head_err_d = tail_err_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (push && new_ok) begin
      digit_cnt_d = digit_cnt_q + 1'b1;
    end

    if (push && !new_ok) begin
      err_sticky_d = 1'b1;
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      head_y_q     <= '0;
      head_err_q   <= 1'b0;
      tail_y_q     <= '0;
      tail_err_q   <= 1'b0;
      digit_cnt_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_y_q     <= head_y_d;
      head_err_q   <= head_err_d;
      tail_y_q     <= tail_y_d;
      tail_err_q   <= tail_err_d;
      digit_cnt_q  <= digit_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef BCD_DEC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign err_cnt = err_cnt_q;

  // Clearing and counting in the same cycle leaves exactly one error recorded.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = (push && !new_ok) ? CNT_W'(1) : '0;
    end else if (push && !new_ok && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_stream_decoder.sv
// Self-checking bench for bcd_stream_decoder: negedge scoreboard monitor plus per-scenario tasks.
// Built with CNT_W=4 so digit_cnt wrap and err_cnt saturation are reachable quickly.
module tb_bcd_stream_decoder;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_bcd;
  logic             out_valid;
  logic             out_ready;
  logic [9:0]       out_y;
  logic             out_err;
  logic [CNT_W-1:0] digit_cnt;
  logic             err_sticky;
  logic             clr_err;
`ifdef BCD_DEC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [10:0]      sb[$];
  logic [CNT_W-1:0] m_cnt    = '0;
  logic             m_sticky = 1'b0;
  logic [CNT_W-1:0] m_errcnt = '0;
  logic             mon_en   = 1'b0;

  bcd_stream_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bcd     (in_bcd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_err    (out_err),
    .digit_cnt  (digit_cnt),
    .err_sticky (err_sticky),
    .clr_err    (clr_err)
`ifdef BCD_DEC_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] decode(input logic [3:0] c);
    logic [10:0] r;
    r = '0;
    if (c < 4'd10) r[c] = 1'b1;
    else           r[10] = 1'b1;
    return r;
  endfunction

  // Scoreboard: compare DUT against the model, then advance the model to the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic        exp_ready, do_push, do_pop, inv;
      logic [10:0] head;
      exp_ready = !rst && (sb.size() < 2);
      head      = (sb.size() > 0) ? sb[0] : 11'b0;
      checks += 5;
      if (in_ready !== exp_ready) begin
        failures++; $display("[TB] FAIL mon_in_ready got=%b exp=%b", in_ready, exp_ready);
      end
      if (out_valid !== (sb.size() > 0)) begin
        failures++; $display("[TB] FAIL mon_out_valid got=%b exp=%b", out_valid, sb.size() > 0);
      end
      if ({out_err, out_y} !== head) begin
        failures++; $display("[TB] FAIL mon_head got=%b/%b exp=%b/%b", out_err, out_y, head[10], head[9:0]);
      end
      if (digit_cnt !== m_cnt) begin
        failures++; $display("[TB] FAIL mon_digit_cnt got=%0d exp=%0d", digit_cnt, m_cnt);
      end
      if (err_sticky !== m_sticky) begin
        failures++; $display("[TB] FAIL mon_err_sticky got=%b exp=%b", err_sticky, m_sticky);
      end
`ifdef BCD_DEC_ERR_CNT_EN
      checks++;
      if (err_cnt !== m_errcnt) begin
        failures++; $display("[TB] FAIL mon_err_cnt got=%0d exp=%0d", err_cnt, m_errcnt);
      end
`endif
      if (rst) begin
        sb.delete();
        m_cnt = '0; m_sticky = 1'b0; m_errcnt = '0;
      end else begin
        do_pop  = (sb.size() > 0) && out_ready;
        do_push = in_valid && exp_ready;
        inv     = in_bcd > 4'd9;
        if (do_pop)  void'(sb.pop_front());
        if (do_push) sb.push_back(decode(in_bcd));
        if (do_push && !inv) m_cnt = m_cnt + 1'b1;
        if (do_push && inv) m_sticky = 1'b1;
        else if (clr_err)   m_sticky = 1'b0;
        if (clr_err) m_errcnt = (do_push && inv) ? CNT_W'(1) : '0;
        else if (do_push && inv && m_errcnt != {CNT_W{1'b1}}) m_errcnt = m_errcnt + 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0; clr_err = 1'b0;
    tick();
    mon_en = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    tick();
    rst = 1'b0;
    #0;
    checks += 2;
    if (out_valid !== 1'b0 || out_y !== 10'd0) begin
      failures++; $display("[TB] FAIL reset_out got=%b/%b exp=0/0", out_valid, out_y);
    end
    if (digit_cnt !== '0 || err_sticky !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_counters got=%0d/%b exp=0/0", digit_cnt, err_sticky);
    end
    tick();
  endtask

  task automatic test_digits();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_bcd = 4'(i);
      tick();
      checks++;
      if (out_y !== (10'd1 << i) || out_err !== 1'b0) begin
        failures++; $display("[TB] FAIL digit_%0d got=%b exp=%b", i, out_y, 10'd1 << i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (digit_cnt !== 4'd10 || err_sticky !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL digits_done got=%0d/%b/%b exp=10/0/0", digit_cnt, err_sticky, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_bcd = 4'd3;
    tick();
    in_bcd = 4'd7;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_y !== 10'd8) begin
      failures++; $display("[TB] FAIL bp_full got=%b/%0d exp=0/8", in_ready, out_y);
    end
    tick(); tick();
    checks++;
    if (out_y !== 10'd8) begin
      failures++; $display("[TB] FAIL bp_hold got=%0d exp=8", out_y);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_y !== 10'd128) begin
      failures++; $display("[TB] FAIL bp_second got=%0d exp=128", out_y);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_y !== 10'd0) begin
      failures++; $display("[TB] FAIL bp_drained got=%b/%0d exp=0/0", out_valid, out_y);
    end
  endtask

  task automatic test_invalid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_bcd = 4'd12;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_y !== 10'd0 || out_err !== 1'b1 || err_sticky !== 1'b1 || digit_cnt !== 4'd12) begin
      failures++; $display("[TB] FAIL inv_entry got=%0d/%b/%b/%0d exp=0/1/1/12", out_y, out_err, err_sticky, digit_cnt);
    end
    out_ready = 1'b1; clr_err = 1'b1;
    tick();
    checks++;
    if (err_sticky !== 1'b0) begin
      failures++; $display("[TB] FAIL inv_clear got=%b exp=0", err_sticky);
    end
    in_valid = 1'b1; in_bcd = 4'd15;
    tick();
    in_valid = 1'b0; clr_err = 1'b0;
    checks++;
    if (err_sticky !== 1'b1 || out_err !== 1'b1) begin
      failures++; $display("[TB] FAIL inv_set_wins got=%b/%b exp=1/1", err_sticky, out_err);
    end
`ifdef BCD_DEC_ERR_CNT_EN
    checks++;
    if (err_cnt !== 4'd1) begin
      failures++; $display("[TB] FAIL inv_errcnt_clr_push got=%0d exp=1", err_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_bcd = (i % 2 == 0) ? 4'd5 : 4'd9;
      tick();
      checks++;
      if (out_y !== ((i % 2 == 0) ? 10'd32 : 10'd512) || in_ready !== 1'b1) begin
        failures++; $display("[TB] FAIL b2b_%0d got=%0d/%b", i, out_y, in_ready);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_bcd = 4'd1;
    tick();
    in_bcd = 4'd2;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || digit_cnt !== '0 || err_sticky !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst got=%b/%b/%0d/%b exp=0/1/0/0", out_valid, in_ready, digit_cnt, err_sticky);
    end
    out_ready = 1'b1;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_no_emit got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_bcd = 4'(i % 10);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (digit_cnt !== 4'd1) begin
      failures++; $display("[TB] FAIL wrap_digit_cnt got=%0d exp=1", digit_cnt);
    end
`ifdef BCD_DEC_ERR_CNT_EN
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_bcd = 4'(10 + (i % 6));
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (err_cnt !== 4'd15) begin
      failures++; $display("[TB] FAIL sat_err_cnt got=%0d exp=15", err_cnt);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_digits();
    test_backpressure();
    test_invalid();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("[TB] FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
